// File: rtl/relax_if.sv
// Bus bundle between the relaxation engine and its distance queue, adjacency
// store and controller; prefixes are from the engine's point of view.
interface relax_if #(
  parameter int MAX_NODES   = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int VALUE_WIDTH = 8
);
  logic                     i_start;
  logic [INDEX_WIDTH-1:0]   i_source;
  logic [2*INDEX_WIDTH-1:0] o_adj_addr;
  logic [VALUE_WIDTH-1:0]   i_adj_weight;
  logic                     o_pq_init;
  logic                     o_pq_set_en;
  logic [INDEX_WIDTH-1:0]   o_pq_index;
  logic [VALUE_WIDTH-1:0]   o_pq_write_value;
  logic [VALUE_WIDTH-1:0]   i_pq_read_value;
  logic [INDEX_WIDTH-1:0]   i_pq_min_index;
  logic [VALUE_WIDTH-1:0]   i_pq_min_value;
  logic [MAX_NODES-1:0]     o_visited_vector;
  logic [INDEX_WIDTH-1:0]   i_pred_query;
  logic [INDEX_WIDTH-1:0]   o_pred_out;
  logic                     o_busy;
  logic                     o_done;

  modport master (
    input  i_start, i_source, i_adj_weight, i_pq_read_value,
           i_pq_min_index, i_pq_min_value, i_pred_query,
    output o_adj_addr, o_pq_init, o_pq_set_en, o_pq_index, o_pq_write_value,
           o_visited_vector, o_pred_out, o_busy, o_done
  );

  modport slave (
    output i_start, i_source, i_adj_weight, i_pq_read_value,
           i_pq_min_index, i_pq_min_value, i_pred_query,
    input  o_adj_addr, o_pq_init, o_pq_set_en, o_pq_index, o_pq_write_value,
           o_visited_vector, o_pred_out, o_busy, o_done
  );
endinterface

// File: rtl/relax_engine.sv
// Dijkstra edge-relaxation controller: selects the nearest unvisited node from
// an external distance queue and relaxes all its outgoing edges, one per two cycles.
module relax_engine #(
  parameter int MAX_NODES   = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int VALUE_WIDTH = 8
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  relax_if.master  bus
);

  localparam logic [VALUE_WIDTH-1:0] INF      = {VALUE_WIDTH{1'b1}};
  localparam logic [VALUE_WIDTH:0]   INF_EXT  = {1'b0, {VALUE_WIDTH{1'b1}}};
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(MAX_NODES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SELECT = 3'd2,
    S_ADDR   = 3'd3,
    S_RELAX  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                   r_state;
  state_t                   w_next_state;
  logic [INDEX_WIDTH-1:0]   r_src;
  logic [INDEX_WIDTH-1:0]   r_u;
  logic [VALUE_WIDTH-1:0]   r_du;
  logic [INDEX_WIDTH-1:0]   r_v;
  logic [MAX_NODES-1:0]     r_visited;
  logic [INDEX_WIDTH-1:0]   r_pred [MAX_NODES];
  logic                     r_busy;
  logic                     r_done;

  logic [2*INDEX_WIDTH-1:0] w_adj_addr;
  logic                     w_pq_init;
  logic                     w_pq_set_en;
  logic [INDEX_WIDTH-1:0]   w_pq_index;
  logic [VALUE_WIDTH-1:0]   w_pq_write_value;
  logic [VALUE_WIDTH:0]     w_sum;
  logic                     w_relax_ok;

  // State register and status flags derived from the next state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == S_INIT) || (w_next_state == S_SELECT) ||
                 (w_next_state == S_ADDR) || (w_next_state == S_RELAX);
      r_done  <= (w_next_state == S_DONE);
    end
  end

  // Next-state and queue/adjacency strobes
  always_comb begin
    w_next_state     = r_state;
    w_adj_addr       = '0;
    w_pq_init        = 1'b0;
    w_pq_set_en      = 1'b0;
    w_pq_index       = '0;
    w_pq_write_value = '0;
    // Sum carries one extra bit so a wrapped addition can never look shorter
    w_sum            = {1'b0, r_du} + {1'b0, bus.i_adj_weight};
    w_relax_ok       = !r_visited[r_v] && (bus.i_adj_weight != INF) &&
                       (w_sum < INF_EXT) && (w_sum < {1'b0, bus.i_pq_read_value});
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.i_start) begin
          w_next_state = S_INIT;
        end else begin
          w_next_state = r_state;
        end
      end
      S_INIT: begin
        w_pq_init    = 1'b1;
        w_pq_index   = r_src;
        w_next_state = S_SELECT;
      end
      S_SELECT: begin
        if ((&r_visited) || (bus.i_pq_min_value == INF)) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_ADDR;
        end
      end
      S_ADDR: begin
        w_adj_addr   = {r_u, r_v};
        w_next_state = S_RELAX;
      end
      S_RELAX: begin
        w_pq_index = r_v;
        if (w_relax_ok) begin
          w_pq_set_en      = 1'b1;
          w_pq_write_value = w_sum[VALUE_WIDTH-1:0];
        end else begin
          w_pq_set_en      = 1'b0;
        end
        if (r_v == LAST_IDX) begin
          w_next_state = S_SELECT;
        end else begin
          w_next_state = S_ADDR;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: source latch, selected node, edge cursor, visited and predecessor table
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src     <= '0;
      r_u       <= '0;
      r_du      <= '0;
      r_v       <= '0;
      r_visited <= '0;
      for (int i = 0; i < MAX_NODES; i++) begin
        r_pred[i] <= INDEX_WIDTH'(i);
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.i_start) begin
            r_src <= bus.i_source;
          end
        end
        S_INIT: begin
          r_visited <= '0;
          for (int i = 0; i < MAX_NODES; i++) begin
            r_pred[i] <= INDEX_WIDTH'(i);
          end
        end
        S_SELECT: begin
          if (w_next_state == S_ADDR) begin
            r_u                           <= bus.i_pq_min_index;
            r_du                          <= bus.i_pq_min_value;
            r_visited[bus.i_pq_min_index] <= 1'b1;
            r_v                           <= '0;
          end
        end
        S_RELAX: begin
          if (w_relax_ok) begin
            r_pred[r_v] <= r_u;
          end
          if (r_v != LAST_IDX) begin
            r_v <= r_v + INDEX_WIDTH'(1'b1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_adj_addr       = w_adj_addr;
  assign bus.o_pq_init        = w_pq_init;
  assign bus.o_pq_set_en      = w_pq_set_en;
  assign bus.o_pq_index       = w_pq_index;
  assign bus.o_pq_write_value = w_pq_write_value;
  assign bus.o_visited_vector = r_visited;
  assign bus.o_pred_out       = r_pred[bus.i_pred_query];
  assign bus.o_busy           = r_busy;
  assign bus.o_done           = r_done;

endmodule

// File: doc/relax_engine.md
RELAX_ENGINE -- requirements
Module: relax_engine

Interface
REQ-001 Parameter MAX_NODES, default 8, number of graph nodes.
REQ-002 Parameter INDEX_WIDTH, default 3, node index width.
REQ-003 Parameter VALUE_WIDTH, default 8, distance/weight width; INFINITY = all ones.
REQ-004 clock  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin a run; sampled only in IDLE or DONE.
REQ-007 source  in  INDEX_WIDTH  source node; latched when start is accepted.
REQ-008 adj_addr  out  2*INDEX_WIDTH  {u,v} address of the directed edge u->v weight.
REQ-009 adj_weight  in  VALUE_WIDTH  weight for the adj_addr presented in the previous cycle; INFINITY = no edge.
REQ-010 pq_init  out  1  synchronous, active-high initialisation strobe to the distance queue.
REQ-011 pq_set_en  out  1  distance write strobe to the queue.
REQ-012 pq_index  out  INDEX_WIDTH  queue access index.
REQ-013 pq_write_value  out  VALUE_WIDTH  distance to write.
REQ-014 pq_read_value  in  VALUE_WIDTH  combinational distance of pq_index.
REQ-015 pq_min_index / pq_min_value  in  INDEX_WIDTH / VALUE_WIDTH  unvisited node with the smallest distance, and its distance.
REQ-016 visited_vector  out  MAX_NODES  registered visited flags; bit = 1 means visited.
REQ-017 pred_query  in  INDEX_WIDTH; pred_out  out  INDEX_WIDTH; pred_out is the combinational predecessor of pred_query.
REQ-018 busy  out  1; done  out  1.

Function
REQ-019 States: IDLE, INIT, SELECT, ADDR, RELAX, DONE.
REQ-020 IDLE/DONE with start=1: latch source and go to INIT; start is ignored in all other states.
REQ-021 INIT, one cycle: drive pq_init=1 with pq_index=source, clear visited_vector, set pred[i]=i for all i, then go to SELECT.
REQ-022 SELECT, one cycle: if all bits of visited_vector are set, or pq_min_value==INFINITY, go to DONE.
REQ-023 SELECT, otherwise: latch u=pq_min_index and du=pq_min_value, set visited[u], set v=0, and go to ADDR.
REQ-024 ADDR: adj_addr={u,v}, then go to RELAX.
REQ-025 RELAX, same-cycle read: pq_index=v; sum = du + adj_weight, computed at VALUE_WIDTH+1 bits.
REQ-026 RELAX update: pq_set_en=1, pq_write_value=sum[VALUE_WIDTH-1:0] and pred[v]=u in the same cycle, only when all of the following hold:
  - visited[v]=0
  - adj_weight != INFINITY
  - sum < INFINITY
  - sum < pq_read_value
REQ-027 RELAX exit: if v==MAX_NODES-1 go to SELECT; else v=v+1 and go to ADDR. Each selected node costs 1+2*MAX_NODES cycles.
REQ-028 Output defaults whenever not driven above: pq_set_en=0, pq_init=0, pq_index=0, pq_write_value=0, adj_addr=0.
REQ-029 busy=1 in INIT, SELECT, ADDR and RELAX; done=1 only in DONE and held until the next accepted start.
REQ-030 pq_set_en and pq_init are never asserted in the same cycle.
REQ-031 The self-edge u->u is never written, because visited[u] is already set.

Reset
REQ-032 On reset assertion (asynchronous, any state), the following take effect immediately:
  - state = IDLE
  - busy = 0, done = 0
  - visited_vector = 0
  - pq_set_en = 0, pq_init = 0
  - pred[i] = i
  - all datapath registers = 0
REQ-033 On reset, no queue write or init is issued; the next start performs a full INIT.

Verification (MAX_NODES=4, VALUE_WIDTH=8, INFINITY=255, queue model attached)
REQ-034 Chain 0->1 w3, 1->2 w4, 2->3 w5, source 0 -> final distances 0,3,7,12; pred 0,0,1,2; done rises 38 cycles after start is sampled.
REQ-035 Later shorter path: edges 0->1 w10, 0->2 w2, 2->1 w3 -> node 1 is written 10 then 5; pred[1]=2; distances 0,5,2,255.
REQ-036 Unreachable node 3 and saturation: edges 0->1 w200, 1->2 w100 -> no write to node 2 (sum 300); SELECT exits early on pq_min_value=255; distances 0,200,255,255; pred[2]=2.
REQ-037 Reset asserted during RELAX with pq_set_en=1 -> pq_set_en, busy and visited_vector go to 0 immediately, with no clock edge; a new start then reproduces the REQ-034 result.
REQ-038 start pulsed while busy -> ignored: source is unchanged and the run result is identical; start while done=1 -> a new run begins with INIT.
